interboard_receiver: RTL and testbench

Receive-side engine of the inter-board link: runs the four-phase Request/Ack handshake as responder and reassembles four 6-bit chunks into one game-control message. Delivers the message to game control as a one-cycle `interboard_en` pulse with registered fields. Sits under the communication top level, beside the sender. The top level gates `Ack_out`, overrides it for the reset pattern, and decodes `interboard_rst`.

---
 rtl/interboard_pkg.sv | 23 ++
 rtl/bit_synchronizer.sv | 18 +
 rtl/interboard_receiver.sv | 105 ++++++++++
 tb/tb_interboard_receiver.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/interboard_pkg.sv
// interboard_pkg: frame layout, field offsets and receiver FSM states shared by the inter-board link
package interboard_pkg;
  localparam int N_CHUNKS = 4;
  localparam int CHUNK_W = 6;
  localparam int FRAME_W = 24;
  localparam int MOVE_DIR_W = 1;
  localparam int BLOCK_X_W = 5;
  localparam int BLOCK_Y_W = 3;
  localparam int MSG_TYPE_W = 4;
  localparam int CARD_W = 6;
  localparam int SEL_LEN_W = 3;
  localparam int SEL_LEN_LSB = 0;
  localparam int CARD_LSB = SEL_LEN_LSB + SEL_LEN_W;
  localparam int MSG_TYPE_LSB = CARD_LSB + CARD_W;
  localparam int BLOCK_Y_LSB = MSG_TYPE_LSB + MSG_TYPE_W;
  localparam int BLOCK_X_LSB = BLOCK_Y_LSB + BLOCK_Y_W;
  localparam int MOVE_DIR_LSB = BLOCK_X_LSB + BLOCK_X_W;
  typedef enum logic [1:0] {
    S_WAIT_REQ = 2'd0,
    S_WAIT_REL = 2'd1,
    S_DRAIN    = 2'd2
  } rx_state_t;
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-stage flip-flop synchronizer for a bus sampled as one aligned word
module bit_synchronizer #(
  parameter int WIDTH = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_sync [STAGES];
  // shift the asynchronous word through the stage chain
  always_ff @(posedge clk) begin
    r_sync[0] <= rst ? '0 : i_d;
    for (int i = 1; i < STAGES; i++) r_sync[i] <= rst ? '0 : r_sync[i-1];
  end
  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/interboard_receiver.sv
// interboard_receiver: four-phase handshake responder that reassembles 4 chunks into a game-control message
module interboard_receiver
  import interboard_pkg::*;
#(
  parameter int TIMEOUT = 1_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  interboard_rst,
  input  logic                  Request_in,
  input  logic [CHUNK_W-1:0]    inter_data_in,
  output logic                  Ack_out,
  output logic                  interboard_en,
  output logic                  interboard_move_dir,
  output logic [BLOCK_X_W-1:0]  interboard_block_x,
  output logic [BLOCK_Y_W-1:0]  interboard_block_y,
  output logic [MSG_TYPE_W-1:0] interboard_msg_type,
  output logic [CARD_W-1:0]     interboard_card,
  output logic [SEL_LEN_W-1:0]  interboard_sel_len,
  output logic                  rx_busy,
  output logic                  rx_error
);
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  logic               w_rst;
  logic               w_req_s;
  logic [CHUNK_W-1:0] w_data_s;
  rx_state_t          r_state, w_state_n;
  logic [2:0]         r_cnt, w_cnt_n;
  logic [FRAME_W-1:0] r_shift, w_shift_n;
  logic [WD_W-1:0]    r_wd, w_wd_n;
  logic               w_expire;
  logic               w_deliver;
  assign w_rst = rst | interboard_rst;
  // request and data share one pipeline so a captured chunk always matches its request
  bit_synchronizer #(.WIDTH(CHUNK_W + 1), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(w_rst),
    .i_d({Request_in, inter_data_in}),
    .o_q({w_req_s, w_data_s})
  );
  assign rx_busy = (r_cnt != 3'd0) || (r_state != S_WAIT_REQ);
  assign w_expire = rx_busy && (r_wd == WD_W'(TIMEOUT - 1));
  // next state: abort on watchdog first, otherwise advance the handshake
  always_comb begin
    w_state_n = r_state;
    w_cnt_n = r_cnt;
    w_shift_n = r_shift;
    w_deliver = 1'b0;
    if (w_expire) begin
      w_state_n = w_req_s ? S_DRAIN : S_WAIT_REQ;
      w_cnt_n = '0;
      w_shift_n = '0;
    end else if (r_state == S_WAIT_REQ && w_req_s) begin
      w_state_n = S_WAIT_REL;
      w_cnt_n = r_cnt + 3'd1;
      w_shift_n = {r_shift[FRAME_W-CHUNK_W-1:0], w_data_s};
    end else if (r_state == S_WAIT_REL && !w_req_s) begin
      w_state_n = S_WAIT_REQ;
      w_deliver = (r_cnt == 3'(N_CHUNKS));
      w_cnt_n = w_deliver ? 3'd0 : r_cnt;
    end else if (r_state == S_DRAIN && !w_req_s) begin
      w_state_n = S_WAIT_REQ;
    end
    w_wd_n = (w_expire || w_state_n != r_state || !rx_busy) ? '0 : r_wd + 1'b1;
  end
  // state, counters and handshake/strobe outputs
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state <= S_WAIT_REQ;
      r_cnt <= '0;
      r_shift <= '0;
      r_wd <= '0;
      Ack_out <= 1'b0;
      interboard_en <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt <= w_cnt_n;
      r_shift <= w_shift_n;
      r_wd <= w_wd_n;
      Ack_out <= (w_state_n == S_WAIT_REL);
      interboard_en <= w_deliver;
      rx_error <= w_expire;
    end
  end
  // decoded fields change only together with a delivered message
  always_ff @(posedge clk) begin
    if (w_rst) begin
      interboard_move_dir <= '0;
      interboard_block_x <= '0;
      interboard_block_y <= '0;
      interboard_msg_type <= '0;
      interboard_card <= '0;
      interboard_sel_len <= '0;
    end else if (w_deliver) begin
      interboard_move_dir <= r_shift[MOVE_DIR_LSB];
      interboard_block_x <= r_shift[BLOCK_X_LSB +: BLOCK_X_W];
      interboard_block_y <= r_shift[BLOCK_Y_LSB +: BLOCK_Y_W];
      interboard_msg_type <= r_shift[MSG_TYPE_LSB +: MSG_TYPE_W];
      interboard_card <= r_shift[CARD_LSB +: CARD_W];
      interboard_sel_len <= r_shift[SEL_LEN_LSB +: SEL_LEN_W];
    end
  end
endmodule

// File: tb/tb_interboard_receiver.sv
// tb_interboard_receiver: scoreboard bench driving the sender side of the four-phase handshake
module tb_interboard_receiver;
  localparam int TO = 1500;
  typedef struct packed {
    logic       md;
    logic [4:0] x;
    logic [2:0] y;
    logic [3:0] t;
    logic [5:0] c;
    logic [2:0] s;
  } msg_t;
  logic clk = 0;
  logic rst = 1;
  logic interboard_rst = 0;
  logic Request_in = 0;
  logic [5:0] inter_data_in = '0;
  logic Ack_out, interboard_en, interboard_move_dir, rx_busy, rx_error;
  logic [4:0] interboard_block_x;
  logic [2:0] interboard_block_y;
  logic [3:0] interboard_msg_type;
  logic [5:0] interboard_card;
  logic [2:0] interboard_sel_len;
  msg_t exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_err = 0;
  interboard_receiver #(.TIMEOUT(TO), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .interboard_rst(interboard_rst),
    .Request_in(Request_in),
    .inter_data_in(inter_data_in),
    .Ack_out(Ack_out),
    .interboard_en(interboard_en),
    .interboard_move_dir(interboard_move_dir),
    .interboard_block_x(interboard_block_x),
    .interboard_block_y(interboard_block_y),
    .interboard_msg_type(interboard_msg_type),
    .interboard_card(interboard_card),
    .interboard_sel_len(interboard_sel_len),
    .rx_busy(rx_busy),
    .rx_error(rx_error)
  );
  always #5 clk = ~clk;
  function automatic msg_t mk(input logic md, input logic [4:0] x, input logic [2:0] y,
                              input logic [3:0] t, input logic [5:0] c, input logic [2:0] s);
    return {md, x, y, t, c, s};
  endfunction
  function automatic logic [21:0] fields();
    return {interboard_move_dir, interboard_block_x, interboard_block_y,
            interboard_msg_type, interboard_card, interboard_sel_len};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  task automatic monitor();
    msg_t e;
    forever begin
      @(negedge clk);
      if (rx_error) n_err++;
      if (interboard_en) begin
        chk("en_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("msg_fields", 32'(fields()), 32'(e));
        end
      end
    end
  endtask
  task automatic send_chunk(input logic [5:0] d, input int hold, input bit lag);
    int n;
    inter_data_in = d;
    @(posedge clk); #1;
    Request_in = 1;
    n = 0;
    do begin @(posedge clk); n++; #1; end while (!Ack_out && n < 20);
    if (lag) chk("ack_rise_lag", n, 3);
    else if (!Ack_out) chk("ack_rise", Ack_out, 1);
    repeat (hold) @(posedge clk);
    #1 Request_in = 0;
    n = 0;
    do begin @(posedge clk); n++; #1; end while (Ack_out && n < 20);
    if (lag) chk("ack_fall_lag", n, 3);
    else if (Ack_out) chk("ack_fall", Ack_out, 0);
  endtask
  task automatic send_msg(input msg_t m, input int hold, input bit lag);
    logic [23:0] f;
    f = {2'b00, m};
    exp_q.push_back(m);
    for (int i = 0; i < 4; i++) send_chunk(f[23-6*i -: 6], hold, lag);
  endtask
  task automatic stimulus();
    msg_t m1, m2, m3, m4, m5, m6;
    logic [23:0] f;
    int n;
    m1 = mk(1'b1, 5'd17, 3'd5, 4'd9, 6'd42, 3'd3);
    m2 = mk(1'b0, 5'd31, 3'd0, 4'd15, 6'd63, 3'd7);
    m3 = mk(1'b1, 5'd0, 3'd7, 4'd0, 6'd0, 3'd0);
    m4 = mk(1'b0, 5'd10, 3'd3, 4'd4, 6'd21, 3'd5);
    m5 = mk(1'b1, 5'd5, 3'd2, 4'd12, 6'd7, 3'd1);
    m6 = mk(1'b0, 5'd22, 3'd6, 4'd3, 6'd50, 3'd6);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({Ack_out, interboard_en, rx_busy, rx_error, fields()}), 32'd0);
    rst = 0;
    send_msg(m1, 2, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("single_drained", exp_q.size(), 0);
    chk("fields_hold", 32'(fields()), 32'(m1));
    send_msg(m2, 0, 0);
    send_msg(m3, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_drained", exp_q.size(), 0);
    f = {2'b00, m4};
    send_chunk(f[23:18], 1, 0);
    send_chunk(f[17:12], 1, 0);
    inter_data_in = f[11:6];
    @(posedge clk); #1;
    Request_in = 1;
    n = 0;
    do begin @(posedge clk); n++; #1; end while (!Ack_out && n < 20);
    n = 0;
    do begin @(posedge clk); n++; #1; end while (!rx_error && n < TO + 20);
    chk("timeout_cycles", n, TO);
    chk("timeout_ack_drop", Ack_out, 0);
    chk("drain_busy", rx_busy, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("drain_no_ack", Ack_out, 0);
    Request_in = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("drain_exit_idle", rx_busy, 0);
    send_msg(m4, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("after_timeout_drained", exp_q.size(), 0);
    f = {2'b00, m6};
    send_chunk(f[23:18], 1, 0);
    send_chunk(f[17:12], 1, 0);
    send_chunk(f[11:6], 1, 0);
    interboard_rst = 1;
    @(posedge clk); #1;
    chk("ibrst_ack", Ack_out, 0);
    chk("ibrst_cnt", 32'(dut.r_cnt), 0);
    chk("ibrst_busy", rx_busy, 0);
    interboard_rst = 0;
    send_msg(m5, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("after_ibrst_drained", exp_q.size(), 0);
    send_msg(m6, 1000, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("slow_drained", exp_q.size(), 0);
    chk("slow_fields", 32'(fields()), 32'(m6));
    rst = 1;
    inter_data_in = 6'h2B;
    Request_in = 1;
    repeat (4) @(posedge clk);
    #1 rst = 0;
    n = 0;
    do begin @(posedge clk); n++; #1; end while (!Ack_out && n < 20);
    chk("rst_req_lag", n, 3);
    chk("rst_req_cnt", 32'(dut.r_cnt), 1);
    chk("rst_req_shift", 32'(dut.r_shift), 32'h2B);
    Request_in = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("error_pulses", n_err, 1);
    chk("final_drained", exp_q.size(), 0);
  endtask
  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
